// File: rtl/out_quantizer_pkg.sv
// Shared types and helpers for the out_quantizer writeback stage:
// FSM state encoding, FIFO sizing and the per-lane threshold quantizer.
package out_quantizer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } oq_state_e;

  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_PTR_W = 2;
  localparam int FIFO_CNT_W = 3;
  // Lanes are sign-extended to this width before comparing.
  localparam int QW         = 32;

  function automatic logic [1:0] quantize_lane(
    input logic signed [QW-1:0] acc,
    input logic signed [QW-1:0] t0,
    input logic signed [QW-1:0] t1,
    input logic signed [QW-1:0] t2,
    input logic                 inv
  );
    logic c0;
    logic c1;
    logic c2;
    if (inv) begin
      c0 = (acc <= t0);
      c1 = (acc <= t1);
      c2 = (acc <= t2);
    end else begin
      c0 = (acc >= t0);
      c1 = (acc >= t1);
      c2 = (acc >= t2);
    end
    return {1'b0, c0} + {1'b0, c1} + {1'b0, c2};
  endfunction

endpackage

// File: rtl/oq_fifo.sv
// Four-entry synchronous FIFO with occupancy count; push and pop may coincide.
// The head word is always visible on head_o; callers guard pop/push with count_o.
module oq_fifo
  import out_quantizer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      push_data_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      head_o,
  output logic [FIFO_CNT_W-1:0] count_o
);

  logic [WIDTH-1:0]      mem_q [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] wr_ptr_q;
  logic [FIFO_PTR_W-1:0] rd_ptr_q;
  logic [FIFO_CNT_W-1:0] count_q;
  logic [FIFO_CNT_W-1:0] count_d;

  // Occupancy next-state.
  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + FIFO_CNT_W'(1);
      2'b01:   count_d = count_q - FIFO_CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage, pointers and count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        mem_q[k] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + FIFO_PTR_W'(1);
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + FIFO_PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/out_quantizer.sv
// Sweeps the accumulator tile buffer in raster order, threshold-quantizes every
// lane to a 2-bit code and streams packed codes over valid/ready with credit-based flow control.
module out_quantizer
  import out_quantizer_pkg::*;
#(
  parameter int  OUT_DATA_WIDTH  = 16,
  parameter int  OC_UNROLL_WIDTH = 4,
  parameter int  TILE_SIZE_WIDTH = 5,
  localparam int OC_UNROLL_NUM   = 1 << OC_UNROLL_WIDTH,
  localparam int OUT_ADDR_WIDTH  = 2 * TILE_SIZE_WIDTH
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    start,
  input  logic [TILE_SIZE_WIDTH-1:0]              oh_last,
  input  logic [TILE_SIZE_WIDTH-1:0]              ow_last,
  input  logic [3*OUT_DATA_WIDTH*OC_UNROLL_NUM-1:0] th,
  input  logic [OC_UNROLL_NUM-1:0]                th_inv,
  output logic [OUT_ADDR_WIDTH-1:0]               buf_raddr,
  input  logic [OUT_DATA_WIDTH*OC_UNROLL_NUM-1:0] buf_rdata,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [2*OC_UNROLL_NUM-1:0]              out_data,
  output logic [OUT_ADDR_WIDTH-1:0]               out_addr,
  output logic                                    out_last,
  output logic                                    busy,
  output logic                                    done
);

  localparam int W  = OUT_DATA_WIDTH;
  localparam int FW = 2 * OC_UNROLL_NUM + OUT_ADDR_WIDTH + 1;

  oq_state_e                   state_q, state_d;
  logic [TILE_SIZE_WIDTH-1:0]  oh_q, oh_d, ow_q, ow_d;
  logic [TILE_SIZE_WIDTH-1:0]  oh_last_q, oh_last_d, ow_last_q, ow_last_d;
  logic [1:0]                  inflight_q, inflight_d;
  logic                        rd_vld_q;
  logic [OUT_ADDR_WIDTH-1:0]   rd_addr_q;
  logic                        rd_last_q;

  logic                        issue_s;
  logic                        at_last_s;
  logic                        pop_s;
  logic [FIFO_CNT_W-1:0]       fifo_count_s;
  logic [FW-1:0]               fifo_head_s;
  logic [2*OC_UNROLL_NUM-1:0]  codes_s;

  assign at_last_s = (oh_q == oh_last_q) && (ow_q == ow_last_q);
  // Reads already issued count against FIFO space so the FIFO can never overflow.
  assign issue_s   = (state_q == ST_RUN) &&
                     (({1'b0, inflight_q} + fifo_count_s) < FIFO_CNT_W'(FIFO_DEPTH));
  assign pop_s     = out_valid && out_ready;

  // FSM next-state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN; else state_d = ST_IDLE;
      ST_RUN:   if (issue_s && at_last_s) state_d = ST_DRAIN; else state_d = ST_RUN;
      ST_DRAIN: if (pop_s && out_last) state_d = ST_DONE; else state_d = ST_DRAIN;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Raster address counters, tile bounds latch and read-credit tracking.
  always_comb begin
    oh_d      = oh_q;
    ow_d      = ow_q;
    oh_last_d = oh_last_q;
    ow_last_d = ow_last_q;
    if ((state_q == ST_IDLE) && start) begin
      oh_d      = '0;
      ow_d      = '0;
      oh_last_d = oh_last;
      ow_last_d = ow_last;
    end else if (issue_s) begin
      if (ow_q == ow_last_q) begin
        ow_d = '0;
        if (at_last_s) oh_d = '0; else oh_d = oh_q + TILE_SIZE_WIDTH'(1);
      end else begin
        ow_d = ow_q + TILE_SIZE_WIDTH'(1);
      end
    end else begin
      oh_d = oh_q;
      ow_d = ow_q;
    end
    case ({issue_s, rd_vld_q})
      2'b10:   inflight_d = inflight_q + 2'd1;
      2'b01:   inflight_d = inflight_q - 2'd1;
      default: inflight_d = inflight_q;
    endcase
  end

  // State, counters and read-metadata pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      oh_q       <= '0;
      ow_q       <= '0;
      oh_last_q  <= '0;
      ow_last_q  <= '0;
      inflight_q <= 2'd0;
      rd_vld_q   <= 1'b0;
      rd_addr_q  <= '0;
      rd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      oh_q       <= oh_d;
      ow_q       <= ow_d;
      oh_last_q  <= oh_last_d;
      ow_last_q  <= ow_last_d;
      inflight_q <= inflight_d;
      rd_vld_q   <= issue_s;
      rd_addr_q  <= {oh_q, ow_q};
      rd_last_q  <= issue_s && at_last_s;
    end
  end

  for (genvar i = 0; i < OC_UNROLL_NUM; i++) begin : g_lane
    logic signed [W-1:0] acc_s, t0_s, t1_s, t2_s;
    assign acc_s = buf_rdata[i*W +: W];
    assign t0_s  = th[3*W*i +: W];
    assign t1_s  = th[3*W*i + W +: W];
    assign t2_s  = th[3*W*i + 2*W +: W];
    assign codes_s[2*i +: 2] = quantize_lane(QW'(acc_s), QW'(t0_s), QW'(t1_s),
                                             QW'(t2_s), th_inv[i]);
  end

  oq_fifo #(.WIDTH(FW)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (rd_vld_q),
    .push_data_i ({rd_last_q, rd_addr_q, codes_s}),
    .pop_i       (pop_s),
    .head_o      (fifo_head_s),
    .count_o     (fifo_count_s)
  );

  assign buf_raddr = {oh_q, ow_q};
  assign out_valid = (fifo_count_s != '0);
  assign out_data  = fifo_head_s[2*OC_UNROLL_NUM-1:0];
  assign out_addr  = fifo_head_s[FW-2 -: OUT_ADDR_WIDTH];
  assign out_last  = fifo_head_s[FW-1];
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);

endmodule
